// File: rtl/pl_if_stage.sv
// pl_if_stage: instruction fetch stage with stall buffer, pending redirect and IF/ID register
module pl_if_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  input  logic        flush,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] dpc4,
  output logic [31:0] inst
);
  typedef enum logic [1:0] {BOOT, REQ, HELD} state_t;
  state_t st, n_st;
  logic [31:0] pc, n_pc, n_dpc4, n_inst, ptgt, n_ptgt, hold_word, n_hold_word, tgt, pc4;
  logic pend, n_pend, redir;
  assign pc4 = pc + 32'd4;
  assign redir = wpcir && pcsource != 2'b00;
  assign tgt = pcsource == 2'b01 ? bpc : pcsource == 2'b10 ? {da[31:2], 2'b00} : jpc;
  assign imem_addr = pc;
  assign imem_req = st == REQ && !reset;
  always_comb begin
    n_st = st;
    n_pc = pc;
    n_dpc4 = dpc4;
    n_inst = inst;
    n_pend = pend;
    n_ptgt = ptgt;
    n_hold_word = hold_word;
    if (st == BOOT) begin
      n_st = REQ;
      if (redir) begin
        n_pend = 1'b1;
        n_ptgt = tgt;
      end
      if (wpcir && flush) n_inst = '0;
    end else if (st == REQ) begin
      if (imem_ready) begin
        if (redir || pend) begin
          // the live redirect wins over the one recorded while the fetch was outstanding
          n_pc = redir ? tgt : ptgt;
          n_pend = 1'b0;
          if (wpcir) n_inst = '0;
        end else if (wpcir && flush) begin
          n_inst = '0;
        end else if (wpcir) begin
          n_dpc4 = pc4;
          n_inst = imem_rdata;
          n_pc = pc4;
        end else begin
          n_hold_word = imem_rdata;
          n_st = HELD;
        end
      end else begin
        if (redir) begin
          n_pend = 1'b1;
          n_ptgt = tgt;
        end
        if (wpcir) n_inst = '0;
      end
    end else if (wpcir) begin
      n_st = REQ;
      if (redir) begin
        n_pc = tgt;
        n_inst = '0;
      end else if (flush) begin
        n_inst = '0;
      end else begin
        n_dpc4 = pc4;
        n_inst = hold_word;
        n_pc = pc4;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= BOOT;
      pc <= '0;
      dpc4 <= '0;
      inst <= '0;
      pend <= 1'b0;
      ptgt <= '0;
      hold_word <= '0;
    end else begin
      st <= n_st;
      pc <= n_pc;
      dpc4 <= n_dpc4;
      inst <= n_inst;
      pend <= n_pend;
      ptgt <= n_ptgt;
      hold_word <= n_hold_word;
    end
  end
endmodule

// File: tb/tb_pl_if_stage.sv
// tb_pl_if_stage: directed self-checking bench for the fetch stage
module tb_pl_if_stage;
  logic clock = 0, reset = 1, wpcir = 1, flush = 0, imem_ready = 0, imem_req;
  logic [31:0] bpc = 0, jpc = 0, da = 0, imem_rdata = 0, imem_addr, dpc4, inst;
  logic [1:0] pcsource = 0;
  int checks = 0, errors = 0;
  pl_if_stage dut (
    .clock(clock), .reset(reset), .bpc(bpc), .jpc(jpc), .da(da), .pcsource(pcsource),
    .wpcir(wpcir), .flush(flush), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .dpc4(dpc4), .inst(inst)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic ifid(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [31:0] i);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_dpc4"}, dpc4, d);
    chk({tag, "_inst"}, inst, i);
  endtask
  initial begin
    imem_ready = 1;
    imem_rdata = 32'hBAD0BAD0;
    step();
    step();
    ifid("rst", 0, 0, 0);
    chk("rst_req", imem_req, 0);
    reset = 0;
    imem_ready = 0;
    step();
    chk("boot_req", imem_req, 1);
    chk("boot_addr", imem_addr, 0);
    imem_ready = 1;
    imem_rdata = 32'h20080001;
    step();
    ifid("f0", 4, 4, 32'h20080001);
    imem_rdata = 32'h20090002;
    step();
    ifid("f1", 8, 8, 32'h20090002);
    imem_rdata = 32'h200A0003;
    wpcir = 0;
    step();
    chk("held_req", imem_req, 0);
    ifid("held0", 8, 8, 32'h20090002);
    imem_ready = 0;
    imem_rdata = 32'h0;
    step();
    step();
    chk("held2_req", imem_req, 0);
    ifid("held2", 8, 8, 32'h20090002);
    wpcir = 1;
    step();
    ifid("rel", 32'hC, 32'hC, 32'h200A0003);
    chk("rel_req", imem_req, 1);
    imem_ready = 1;
    imem_rdata = 32'h12345678;
    flush = 1;
    step();
    ifid("refetch", 32'hC, 32'hC, 0);
    pcsource = 2'b01;
    bpc = 32'h40;
    step();
    chk("br_addr", imem_addr, 32'h40);
    chk("br_inst", inst, 0);
    flush = 0;
    pcsource = 2'b11;
    jpc = 32'h100;
    imem_ready = 0;
    step();
    chk("jpend_addr", imem_addr, 32'h40);
    chk("jpend_inst", inst, 0);
    pcsource = 2'b00;
    step();
    chk("jwait_addr", imem_addr, 32'h40);
    imem_ready = 1;
    imem_rdata = 32'hDEADBEEF;
    step();
    chk("jdone_addr", imem_addr, 32'h100);
    chk("jdone_inst", inst, 0);
    imem_rdata = 32'h11111111;
    step();
    ifid("jfetch", 32'h104, 32'h104, 32'h11111111);
    pcsource = 2'b10;
    da = 32'h203;
    step();
    chk("jr_addr", imem_addr, 32'h200);
    chk("jr_inst", inst, 0);
    pcsource = 2'b11;
    jpc = 32'hFFFFFFFC;
    step();
    chk("top_addr", imem_addr, 32'hFFFFFFFC);
    pcsource = 2'b00;
    imem_rdata = 32'h22;
    step();
    ifid("wrap", 0, 0, 32'h22);
    wpcir = 0;
    imem_rdata = 32'h33;
    step();
    chk("h2_req", imem_req, 0);
    reset = 1;
    wpcir = 1;
    step();
    ifid("rst2", 0, 0, 0);
    chk("rst2_req", imem_req, 0);
    reset = 0;
    imem_ready = 0;
    step();
    chk("rst2_boot_req", imem_req, 1);
    imem_ready = 1;
    imem_rdata = 32'h44;
    step();
    ifid("restart", 4, 4, 32'h44);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
